// File: rtl/cic_readout_sched.sv
// Decimation strobe generator and shadow-bank readout serializer for a CIC channel array.
// Optional frame counter output is built when CIC_SCHED_FRAMECNT_EN is defined.
//
// state | meaning
// IDLE  | no frame pending, out_valid low, waiting for a capture
// SEND  | streaming shadow[idx] to the readout port, channel 0 first
module cic_readout_sched #(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 25,
    parameter int MAX_DEC_LOG2 = 8,
    parameter int SEL_WIDTH    = $clog2(MAX_DEC_LOG2 + 1),
    parameter int CHAN_WIDTH   = $clog2(NUM_CHANNELS)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [SEL_WIDTH-1:0]               dec_log2,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
    output logic                               dec_strobe,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CHAN_WIDTH-1:0]              out_chan,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    input  logic                               overrun_clr,
    output logic                               overrun
`ifdef CIC_SCHED_FRAMECNT_EN
    ,
    output logic [7:0]                         frame_id
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [SEL_WIDTH-1:0]    SEL_ONE  = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0]    SEL_MAX  = SEL_WIDTH'(MAX_DEC_LOG2);
    localparam logic [MAX_DEC_LOG2-1:0] CNT_ONE  = MAX_DEC_LOG2'(1);
    localparam logic [MAX_DEC_LOG2-1:0] CNT_ONES = '1;
    localparam logic [CHAN_WIDTH-1:0]   LAST_IDX = CHAN_WIDTH'(NUM_CHANNELS - 1);
    localparam logic [CHAN_WIDTH-1:0]   IDX_ONE  = CHAN_WIDTH'(1);

    function automatic logic [SEL_WIDTH-1:0] clamp_sel(input logic [SEL_WIDTH-1:0] d);
        logic [SEL_WIDTH-1:0] r;
        r = d;
        if (d == '0) begin
            r = SEL_ONE;
        end else if (d > SEL_MAX) begin
            r = SEL_MAX;
        end
        return r;
    endfunction

    logic [MAX_DEC_LOG2-1:0] cnt;
    logic [MAX_DEC_LOG2-1:0] term;
    logic [SEL_WIDTH-1:0]    active_log2;

    state_t                  state, state_nxt;
    logic [CHAN_WIDTH-1:0]   idx, idx_nxt;
    logic [DATA_WIDTH-1:0]   shadow [NUM_CHANNELS];

    logic                    xfer;
    logic                    last_xfer;
    logic                    capture;
    logic                    drop;

    // Terminal count is 2^active - 1; an all-ones shift covers active = MAX without a wider vector.
    assign term       = ~(CNT_ONES << active_log2);
    assign dec_strobe = enable && (cnt == term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            active_log2 <= SEL_ONE;
        end else if (!enable || dec_strobe) begin
            cnt         <= '0;
            active_log2 <= clamp_sel(dec_log2);
        end else begin
            cnt         <= cnt + CNT_ONE;
        end
    end

    assign out_valid = (state == SEND);
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (idx == LAST_IDX);
    assign capture   = dec_strobe && ((state == IDLE) || last_xfer);
    assign drop      = dec_strobe && (state == SEND) && !last_xfer;

    assign out_data  = out_valid ? shadow[idx] : '0;
    assign out_chan  = idx;
    assign out_last  = out_valid && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (capture) begin
            state_nxt = SEND;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    idx_nxt = '0;
                end
                SEND: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            state_nxt = IDLE;
                            idx_nxt   = '0;
                        end else begin
                            idx_nxt   = idx + IDX_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // The shadow bank only moves on an accepted capture, so a dropped frame leaves it intact.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                shadow[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
                shadow[k] <= ch_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef CIC_SCHED_FRAMECNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_id <= 8'd0;
        end else if (capture) begin
            frame_id <= frame_id + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cic_readout_sched.sv
// Directed bench for cic_readout_sched: strobe periods, ratio clamping, serialization,
// backpressure hold, overrun handling and mid-frame reset.
module tb_cic_readout_sched;

    localparam int NCH = 8;
    localparam int DW  = 25;
    localparam int SW  = 4;
    localparam int CW  = 3;

    logic              clk;
    logic              reset;
    logic              enable;
    logic [SW-1:0]     dec_log2;
    logic [NCH*DW-1:0] ch_data;
    logic              dec_strobe;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_chan;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic              overrun_clr;
    logic              overrun;
`ifdef CIC_SCHED_FRAMECNT_EN
    logic [7:0]        frame_id;
`endif

    int total = 0;
    int bad   = 0;

    cic_readout_sched dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .dec_log2    (dec_log2),
        .ch_data     (ch_data),
        .dec_strobe  (dec_strobe),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_last    (out_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .overrun     (overrun)
`ifdef CIC_SCHED_FRAMECNT_EN
        ,
        .frame_id    (frame_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int f, input int k);
        return DW'(f * 65536 + k * 17 + 1);
    endfunction

    task automatic set_frame(input int f);
        for (int k = 0; k < NCH; k++) begin
            ch_data[k*DW +: DW] = pat(f, k);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps from a strobe cycle to the next strobe and returns the distance in cycles.
    task automatic measure(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (dec_strobe !== 1'b1 && n < 600);
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        while (dec_strobe !== 1'b1 && n < 600) begin
            cyc();
            n++;
        end
    endtask

    // Drains any frame with enable low, clears overrun, then restarts the counter at ratio a.
    task automatic restart(input int a);
        int n;
        enable   = 1'b0;
        dec_log2 = SW'(a);
        out_ready = 1'b1;
        n = 0;
        while (out_valid !== 1'b0 && n < 50) begin
            cyc();
            n++;
        end
        chk("rs_idle", 32'(out_valid), 0);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("rs_ovr_clr", 32'(overrun), 0);
        enable = 1'b1;
        wait_strobe(n);
        chk("rs_first_strobe", 32'(n), 32'((1 << a) - 1));
    endtask

    initial begin
        int n;
        int m;
        int k;

        reset       = 1'b1;
        enable      = 1'b0;
        dec_log2    = 4'd3;
        out_ready   = 1'b1;
        overrun_clr = 1'b0;
        set_frame(1);

        // Reset state
        cyc();
        cyc();
        chk("rst_valid",   32'(out_valid),  0);
        chk("rst_strobe",  32'(dec_strobe), 0);
        chk("rst_overrun", 32'(overrun),    0);
        chk("rst_data",    32'(out_data),   0);
        chk("rst_last",    32'(out_last),   0);
        chk("rst_chan",    32'(out_chan),   0);
`ifdef CIC_SCHED_FRAMECNT_EN
        chk("rst_frame_id", 32'(frame_id), 0);
`endif
        reset = 1'b0;
        cyc();

        // Basic serialization at ratio 8 with ready held high
        enable = 1'b1;
        wait_strobe(n);
        chk("t1_first_strobe", 32'(n), 7);
        for (int i = 0; i < NCH; i++) begin
            cyc();
            if (i == 0) set_frame(2);
            chk("t1_valid",  32'(out_valid),  1);
            chk("t1_chan",   32'(out_chan),   32'(i));
            chk("t1_data",   32'(out_data),   32'(pat(1, i)));
            chk("t1_last",   32'(out_last),   32'(i == NCH - 1));
            chk("t1_strobe", 32'(dec_strobe), 32'(i == NCH - 1));
`ifdef CIC_SCHED_FRAMECNT_EN
            chk("t1_frame_id", 32'(frame_id), 1);
`endif
        end
        cyc();
        chk("t1_b2b_valid", 32'(out_valid), 1);
        chk("t1_b2b_chan",  32'(out_chan),  0);
        chk("t1_b2b_data",  32'(out_data),  32'(pat(2, 0)));
        chk("t1_overrun",   32'(overrun),   0);

        // Ratio clamping and mid-period ratio change
        wait_strobe(n);
        chk("t2_sync", 32'(n), 7);
        dec_log2 = 4'd0;
        measure(n);
        chk("t2_period_lo", 32'(n), 2);
        dec_log2 = 4'd12;
        measure(n);
        chk("t2_period_hi", 32'(n), 256);
        dec_log2 = 4'd3;
        measure(n);
        chk("t2_period_3", 32'(n), 8);
        repeat (3) cyc();
        dec_log2 = 4'd5;
        measure(m);
        chk("t2_mid_change", 32'(m + 3), 8);
        measure(n);
        chk("t2_period_5", 32'(n), 32);

        // Alternating ready at ratio 32
        set_frame(3);
        restart(5);
        k = 0;
        for (int i = 0; i < 2 * NCH; i++) begin
            cyc();
            out_ready = (i % 2 == 1);
            if (i == 0) set_frame(4);
            chk("t3_valid", 32'(out_valid), 1);
            chk("t3_chan",  32'(out_chan),  32'(k));
            chk("t3_data",  32'(out_data),  32'(pat(3, k)));
            chk("t3_last",  32'(out_last),  32'(k == NCH - 1));
            if (out_ready) k++;
        end
        out_ready = 1'b1;
        cyc();
        chk("t3_done_valid", 32'(out_valid), 0);
        chk("t3_overrun",    32'(overrun),   0);

        // Stalled readout at ratio 8: overrun, shadow preserved, clear, set-wins
        set_frame(5);
        restart(3);
        out_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 1) set_frame(6);
        end
        chk("t4_overrun_set", 32'(overrun),   1);
        chk("t4_hold_valid",  32'(out_valid), 1);
        chk("t4_hold_chan",   32'(out_chan),  0);
        chk("t4_hold_data",   32'(out_data),  32'(pat(5, 0)));
        out_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            chk("t4_chan", 32'(out_chan), 32'(i));
            chk("t4_data", 32'(out_data), 32'(pat(5, i)));
            cyc();
        end
        chk("t4_idle", 32'(out_valid), 0);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t4_overrun_clr", 32'(overrun), 0);
        wait_strobe(n);
        chk("t4_sync", 32'(n), 3);
        cyc();
        out_ready = 1'b0;
        wait_strobe(n);
        chk("t4_sync2", 32'(n), 7);
        chk("t4_pre_set", 32'(overrun), 0);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t4_set_wins", 32'(overrun),  1);
        chk("t4_new_data", 32'(out_data), 32'(pat(6, 0)));

        // Final transfer coinciding with the strobe
        enable    = 1'b0;
        out_ready = 1'b1;
        repeat (7) cyc();
        out_ready = 1'b0;
        chk("t5_park_chan", 32'(out_chan), 7);
        chk("t5_park_last", 32'(out_last), 1);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("t5_ovr_clr", 32'(overrun), 0);
        set_frame(7);
        dec_log2 = 4'd3;
        cyc();
        enable = 1'b1;
        repeat (7) cyc();
        chk("t5_strobe", 32'(dec_strobe), 1);
        chk("t5_chan7",  32'(out_chan),   7);
        chk("t5_data7",  32'(out_data),   32'(pat(6, 7)));
        out_ready = 1'b1;
        cyc();
        chk("t5_nogap_valid", 32'(out_valid), 1);
        chk("t5_nogap_chan",  32'(out_chan),  0);
        chk("t5_nogap_data",  32'(out_data),  32'(pat(7, 0)));
        chk("t5_overrun",     32'(overrun),   0);

        // Reset in the middle of a frame
        repeat (4) cyc();
        chk("t6_mid_chan", 32'(out_chan), 4);
        set_frame(8);
        dec_log2 = 4'd0;
        reset = 1'b1;
        #1;
        chk("t6_async_valid",  32'(out_valid),  0);
        chk("t6_async_strobe", 32'(dec_strobe), 0);
        chk("t6_async_chan",   32'(out_chan),   0);
        chk("t6_async_data",   32'(out_data),   0);
`ifdef CIC_SCHED_FRAMECNT_EN
        chk("t6_frame_id_rst", 32'(frame_id), 0);
`endif
        cyc();
        reset = 1'b0;
        chk("t6_rel_strobe", 32'(dec_strobe), 0);
        chk("t6_rel_valid",  32'(out_valid),  0);
        cyc();
        chk("t6_first_strobe", 32'(dec_strobe), 1);
        cyc();
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_chan",  32'(out_chan),  0);
        chk("t6_data",  32'(out_data),  32'(pat(8, 0)));
`ifdef CIC_SCHED_FRAMECNT_EN
        chk("t6_frame_id", 32'(frame_id), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
